// File: rtl/lcd_char_refresh_ctrl.sv
// lcd_char_refresh_ctrl: HD44780-class character LCD controller with frame buffer and continuous refresh.
// Optional macro LCD_4BIT_EN selects a 4-bit bus (nibbles on lcd_data[7:4]); default is the 8-bit bus.
module lcd_char_refresh_ctrl #(
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int PWR_DLY  = 1_000_000,
  parameter int E_HALF   = 50_000,
  parameter int CLR_WAIT = 100_000,
  localparam int AW      = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_wdata,
  output logic          init_done,
  output logic          frame_done,
  output logic          lcd_en,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic [7:0]    lcd_data
);
  localparam int N  = ROWS * COLS;
  localparam int TX = 2 * E_HALF;
  localparam int M1 = PWR_DLY > CLR_WAIT ? PWR_DLY : CLR_WAIT;
  localparam int CW = $clog2((M1 > TX ? M1 : TX) + 1);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int KW = $clog2(COLS);
`ifdef LCD_4BIT_EN
  localparam logic [2:0] LAST = 3'd5, CLR = 3'd3, OFS = 3'd1;
  localparam logic [7:0] FSET = 8'h28;
`else
  localparam logic [2:0] LAST = 3'd4, CLR = 3'd2, OFS = 3'd0;
  localparam logic [7:0] FSET = 8'h38;
`endif
  typedef enum logic [2:0] {S_PWR, S_INIT, S_CLRW, S_ROW, S_CHAR} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_q, step_d, k;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] col_q, col_d;
  logic          en_q, en_d, rs_q, rs_d, init_done_q, init_done_d, frame_done_q, frame_done_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    buf_q [N];
  logic [7:0]    buf_d [N];
  logic [AW-1:0] idx;
  logic [7:0]    init_byte, row_byte, cur_byte, out_byte;
  logic          tx, tx_end, byte_end;
`ifdef LCD_4BIT_EN
  logic          nib_q, nib_d, single;
  logic [7:0]    hold_q, hold_d;
`endif
  always_comb begin
    buf_d = buf_q;
    if (buf_we && 32'(buf_addr) < N) buf_d[buf_addr] = buf_wdata;
  end
  // A byte is captured once at its load cycle; a same-cycle write lands in the buffer for the next frame.
  always_comb begin
    k         = step_q - OFS;
    idx       = AW'(int'(row_q) * COLS + int'(col_q));
    init_byte = k == 3'd0 ? FSET : k == 3'd1 ? 8'h08 : k == 3'd2 ? 8'h01 : k == 3'd3 ? 8'h06 : 8'h0C;
    row_byte  = 8'h80 | (row_q[0] ? 8'h40 : 8'h00) | (RW > 1 && row_q[RW-1] ? 8'h14 : 8'h00);
    cur_byte  = state_q == S_CHAR ? buf_q[idx] : state_q == S_ROW ? row_byte : init_byte;
    tx        = state_q == S_INIT || state_q == S_ROW || state_q == S_CHAR;
    tx_end    = tx && cnt_q == CW'(TX - 1);
`ifdef LCD_4BIT_EN
    single    = state_q == S_INIT && step_q == 3'd0;
    out_byte  = single ? 8'h20 : nib_q ? {hold_q[3:0], 4'h0} : {cur_byte[7:4], 4'h0};
    byte_end  = tx_end && (nib_q || single);
`else
    out_byte  = cur_byte;
    byte_end  = tx_end;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWR;
      cnt_q        <= '0;
      step_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      buf_q        <= '{default: 8'h20};
`ifdef LCD_4BIT_EN
      nib_q        <= 1'b0;
      hold_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      row_q        <= row_d;
      col_q        <= col_d;
      en_q         <= en_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      buf_q        <= buf_d;
`ifdef LCD_4BIT_EN
      nib_q        <= nib_d;
      hold_q       <= hold_d;
`endif
    end
  end
  // rs/data load on the second low-phase cycle so they never move while E is high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    step_d       = step_q;
    row_d        = row_q;
    col_d        = col_q;
    en_d         = en_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
`ifdef LCD_4BIT_EN
    nib_d        = nib_q;
    hold_d       = hold_q;
    if (tx && cnt_q == '0 && !nib_q) hold_d = cur_byte;
    if (tx_end) nib_d = !byte_end;
`endif
    if (tx && cnt_q == '0) begin
      data_d = out_byte;
      rs_d   = state_q == S_CHAR;
    end
    if (tx && cnt_q == CW'(E_HALF - 1)) en_d = 1'b1;
    if (tx_end) begin
      cnt_d = '0;
      en_d  = 1'b0;
    end
    case (state_q)
      S_PWR: if (cnt_q == CW'(PWR_DLY - 1)) begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
      S_CLRW: if (cnt_q == CW'(CLR_WAIT - 1)) begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
      S_INIT: if (byte_end) begin
        step_d = step_q + 3'd1;
        if (step_q == LAST) begin
          state_d     = S_ROW;
          row_d       = '0;
          init_done_d = 1'b1;
        end else if (step_q == CLR) state_d = S_CLRW;
      end
      S_ROW: if (byte_end) begin
        state_d = S_CHAR;
        col_d   = '0;
      end
      S_CHAR: if (byte_end) begin
        col_d = col_q + KW'(1);
        if (col_q == KW'(COLS - 1)) begin
          col_d        = '0;
          state_d      = S_ROW;
          row_d        = row_q == RW'(ROWS - 1) ? '0 : row_q + RW'(1);
          frame_done_d = row_q == RW'(ROWS - 1);
        end
      end
      default: state_d = S_PWR;
    endcase
  end
  always_comb begin
    lcd_en     = en_q;
    lcd_rs     = rs_q;
    lcd_rw     = 1'b0;
    lcd_data   = data_q;
    init_done  = init_done_q;
    frame_done = frame_done_q;
  end
endmodule
